// File: rtl/ppu_vram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_arb_if
// Purpose  : Bundle of the render fetch port, the CPU ($2007) access port and
//            the shared PPU memory port seen by the VRAM arbiter.
// Modports : slave  - arbiter side (consumes requests, drives memory strobes)
//            master - environment side (render/CPU requesters and memory)
// Revision : 1.0 - initial release
// ============================================================================
interface ppu_vram_arb_if #(
    parameter int ADDR_W = 14
);
    // Render fetch port
    logic              ren_req;
    logic [ADDR_W-1:0] ren_addr;
    logic              ren_ack;
    logic [7:0]        ren_rdata;
    // CPU access port
    logic              cpu_req;
    logic              cpu_rnw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_busy;
    logic              cpu_done;
    logic [7:0]        cpu_rdata;
    logic              cpu_overrun;
    // Shared memory port
    logic [ADDR_W-1:0] ppu_mem_addr;
    logic [7:0]        ppu_mem_dout;
    logic              ppu_mem_rd_req;
    logic              ppu_mem_wr_req;
    logic              ppu_mem_ack;
    logic [7:0]        ppu_mem_din;

    modport slave (
        input  ren_req, ren_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
               ppu_mem_ack, ppu_mem_din,
        output ren_ack, ren_rdata, cpu_busy, cpu_done, cpu_rdata, cpu_overrun,
               ppu_mem_addr, ppu_mem_dout, ppu_mem_rd_req, ppu_mem_wr_req
    );

    modport master (
        output ren_req, ren_addr, cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
               ppu_mem_ack, ppu_mem_din,
        input  ren_ack, ren_rdata, cpu_busy, cpu_done, cpu_rdata, cpu_overrun,
               ppu_mem_addr, ppu_mem_dout, ppu_mem_rd_req, ppu_mem_wr_req
    );
endinterface
`default_nettype wire

// File: rtl/ppu_vram_arb.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_arb
// Purpose  : Arbitrates PPU VRAM between render fetches and single-entry CPU
//            accesses. Render normally wins; a pending CPU access is forced
//            after STARVE_MAX consecutive render grants.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - ppu_vram_arb_if.slave (render, CPU and memory ports)
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_arb #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    ppu_vram_arb_if.slave bus
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REN_ACC = 2'd1,
        ST_CPU_ACC = 2'd2
    } state_t;

    state_t            state_q;
    logic              slot_vld_q;
    logic              slot_rnw_q;
    logic [ADDR_W-1:0] slot_addr_q;
    logic [7:0]        slot_wdata_q;
    logic [2:0]        starve_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_dout_q;
    logic              rd_req_q;
    logic              wr_req_q;
    logic              cpu_done_q;
    logic              cpu_ovr_q;
    logic [7:0]        cpu_rdata_q;

    // CPU wins the IDLE decision when its slot is pending and render is
    // either absent or has used up its starvation allowance.
    logic cpu_win_d;
    assign cpu_win_d = slot_vld_q && (!bus.ren_req || (starve_q == STARVE_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slot_vld_q   <= 1'b0;
            slot_rnw_q   <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= 8'h00;
            starve_q     <= 3'd0;
            mem_addr_q   <= '0;
            mem_dout_q   <= 8'h00;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            cpu_done_q   <= 1'b0;
            cpu_ovr_q    <= 1'b0;
            cpu_rdata_q  <= 8'h00;
        end else begin
            cpu_done_q <= 1'b0;
            // The slot stays valid through CPU_ACC, so a request landing in
            // the completion cycle still sees busy and is dropped.
            cpu_ovr_q  <= bus.cpu_req && slot_vld_q;

            if (bus.cpu_req && !slot_vld_q) begin
                slot_vld_q   <= 1'b1;
                slot_rnw_q   <= bus.cpu_rnw;
                slot_addr_q  <= bus.cpu_addr;
                slot_wdata_q <= bus.cpu_wdata;
            end

            if (!slot_vld_q) begin
                starve_q <= 3'd0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cpu_win_d) begin
                        state_q    <= ST_CPU_ACC;
                        mem_addr_q <= slot_addr_q;
                        rd_req_q   <= slot_rnw_q;
                        wr_req_q   <= !slot_rnw_q;
                        if (!slot_rnw_q) begin
                            mem_dout_q <= slot_wdata_q;
                        end
                        starve_q   <= 3'd0;
                    end else if (bus.ren_req) begin
                        state_q    <= ST_REN_ACC;
                        mem_addr_q <= bus.ren_addr;
                        rd_req_q   <= 1'b1;
                        if (slot_vld_q && (starve_q != STARVE_LIM)) begin
                            starve_q <= starve_q + 3'd1;
                        end
                    end
                end
                ST_REN_ACC: begin
                    if (bus.ppu_mem_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_CPU_ACC: begin
                    if (bus.ppu_mem_ack) begin
                        rd_req_q   <= 1'b0;
                        wr_req_q   <= 1'b0;
                        cpu_done_q <= 1'b1;
                        if (slot_rnw_q) begin
                            cpu_rdata_q <= bus.ppu_mem_din;
                        end
                        slot_vld_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rd_req_q <= 1'b0;
                    wr_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Render data is forwarded straight from memory in the ack cycle.
    assign bus.ren_ack        = (state_q == ST_REN_ACC) && bus.ppu_mem_ack;
    assign bus.ren_rdata      = bus.ren_ack ? bus.ppu_mem_din : 8'h00;
    assign bus.cpu_busy       = slot_vld_q;
    assign bus.cpu_done       = cpu_done_q;
    assign bus.cpu_rdata      = cpu_rdata_q;
    assign bus.cpu_overrun    = cpu_ovr_q;
    assign bus.ppu_mem_addr   = mem_addr_q;
    assign bus.ppu_mem_dout   = mem_dout_q;
    assign bus.ppu_mem_rd_req = rd_req_q;
    assign bus.ppu_mem_wr_req = wr_req_q;

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ppu_vram_arb
// Purpose  : Self-checking bench for ppu_vram_arb. A transaction-level model
//            (current access owner, CPU slot, starvation count, memory array)
//            predicts every output cycle by cycle under directed and random
//            render/CPU/memory traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_arb;

    localparam int ADDR_W     = 14;
    localparam int STARVE_MAX = 4;
    localparam int OWN_NONE   = 0;
    localparam int OWN_REN    = 1;
    localparam int OWN_CPU    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    ppu_vram_arb_if #(.ADDR_W(ADDR_W)) bus ();

    ppu_vram_arb #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks;
    int n_fail;

    // Reference model state
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    int                owner;
    int                wait_cnt;
    int                lat;
    logic [ADDR_W-1:0] acc_addr;
    bit                m_pend;
    bit                m_rnw;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata;
    int                m_starve;
    bit                e_done;
    bit                e_ovr;
    logic [7:0]        e_rdata;
    bit                ren_ack_seen;

    // Observation counters
    int done_cnt;
    int ren_ack_cnt;
    int ovr_cnt;
    int ren_acks_at_done;
    int arm_mark;

    // Stimulus knobs
    bit                rnd_mode;
    int                fix_lat;
    bit                d_cpu_req;
    bit                d_cpu_arm;
    bit                d_rnw;
    logic [ADDR_W-1:0] d_addr;
    logic [7:0]        d_wdata;
    bit                d_ren_on;
    bit                d_spur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner        = OWN_NONE;
        wait_cnt     = 0;
        lat          = 0;
        m_pend       = 1'b0;
        m_starve     = 0;
        e_done       = 1'b0;
        e_ovr        = 1'b0;
        e_rdata      = 8'h00;
        ren_ack_seen = 1'b0;
        d_cpu_req    = 1'b0;
        d_cpu_arm    = 1'b0;
        d_ren_on     = 1'b0;
        d_spur       = 1'b0;
        bus.ren_req     = 1'b0;
        bus.ren_addr    = '0;
        bus.cpu_req     = 1'b0;
        bus.cpu_rnw     = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = 8'h00;
        bus.ppu_mem_ack = 1'b0;
        bus.ppu_mem_din = 8'h00;
    endtask

    // One clock cycle; entered and left 1 ns after a rising edge.
    task automatic tick();
        bit         ack;
        bit         creq;
        bit         pend_now;
        bit         armed_now;
        logic [7:0] din;

        // Registered outputs against predictions made last cycle
        check_eq("rd_req", 32'(bus.ppu_mem_rd_req),
                 32'((owner == OWN_REN) || (owner == OWN_CPU && m_rnw)));
        check_eq("wr_req", 32'(bus.ppu_mem_wr_req), 32'(owner == OWN_CPU && !m_rnw));
        check_eq("strobe_excl", 32'(bus.ppu_mem_rd_req && bus.ppu_mem_wr_req), 32'd0);
        if (owner != OWN_NONE) check_eq("mem_addr", 32'(bus.ppu_mem_addr), 32'(acc_addr));
        if (owner == OWN_CPU && !m_rnw) check_eq("mem_dout", 32'(bus.ppu_mem_dout), 32'(m_wdata));
        check_eq("cpu_busy", 32'(bus.cpu_busy), 32'(m_pend));
        check_eq("cpu_done", 32'(bus.cpu_done), 32'(e_done));
        check_eq("cpu_overrun", 32'(bus.cpu_overrun), 32'(e_ovr));
        check_eq("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rdata));
        if (bus.cpu_done) begin
            done_cnt++;
            ren_acks_at_done = ren_ack_cnt;
        end
        if (bus.cpu_overrun) ovr_cnt++;

        // Render requester: hold until acked, then drop or issue a new fetch
        if (ren_ack_seen || !bus.ren_req) begin
            if (d_ren_on || (rnd_mode && $urandom_range(0, 2) != 0)) begin
                bus.ren_req  = 1'b1;
                bus.ren_addr = ADDR_W'($urandom);
            end else begin
                bus.ren_req = 1'b0;
            end
        end

        // Memory responder
        ack = 1'b0;
        din = 8'($urandom);
        if (owner != OWN_NONE) begin
            if (wait_cnt == lat) begin
                ack = 1'b1;
                if (owner == OWN_REN || m_rnw) din = mem[acc_addr];
            end
        end else if (d_spur || (rnd_mode && $urandom_range(0, 7) == 0)) begin
            ack    = 1'b1;
            d_spur = 1'b0;
        end
        bus.ppu_mem_ack = ack;
        bus.ppu_mem_din = din;

        // CPU requester
        creq      = 1'b0;
        armed_now = 1'b0;
        if (d_cpu_req || (d_cpu_arm && ack && owner == OWN_REN)) begin
            armed_now     = d_cpu_arm;
            d_cpu_req     = 1'b0;
            d_cpu_arm     = 1'b0;
            creq          = 1'b1;
            bus.cpu_rnw   = d_rnw;
            bus.cpu_addr  = d_addr;
            bus.cpu_wdata = d_wdata;
        end else if (rnd_mode && $urandom_range(0, 5) == 0) begin
            creq          = 1'b1;
            bus.cpu_rnw   = 1'($urandom);
            bus.cpu_addr  = ADDR_W'($urandom);
            bus.cpu_wdata = 8'($urandom);
        end
        bus.cpu_req = creq;

        #1;
        check_eq("ren_ack", 32'(bus.ren_ack), 32'(ack && owner == OWN_REN));
        if (ack && owner == OWN_REN) check_eq("ren_rdata", 32'(bus.ren_rdata), 32'(mem[acc_addr]));
        if (bus.ren_ack) ren_ack_cnt++;
        if (armed_now) arm_mark = ren_ack_cnt;

        // Advance the model to the next cycle
        pend_now     = m_pend;
        e_ovr        = creq && pend_now;
        e_done       = 1'b0;
        ren_ack_seen = ack && owner == OWN_REN;
        if (owner != OWN_NONE) begin
            if (ack) begin
                if (owner == OWN_CPU) begin
                    e_done = 1'b1;
                    if (m_rnw) e_rdata = din;
                    else       mem[acc_addr] = m_wdata;
                    m_pend = 1'b0;
                end
                owner = OWN_NONE;
            end else begin
                wait_cnt++;
            end
        end else begin
            if (pend_now && (!bus.ren_req || m_starve == STARVE_MAX)) begin
                owner    = OWN_CPU;
                acc_addr = m_addr;
                m_starve = 0;
            end else if (bus.ren_req) begin
                owner    = OWN_REN;
                acc_addr = bus.ren_addr;
                if (pend_now && m_starve < STARVE_MAX) m_starve++;
            end
            if (owner != OWN_NONE) begin
                wait_cnt = 0;
                lat      = rnd_mode ? int'($urandom_range(0, 3)) : fix_lat;
            end
        end
        if (!pend_now) m_starve = 0;
        if (creq && !pend_now) begin
            m_pend  = 1'b1;
            m_rnw   = bus.cpu_rnw;
            m_addr  = bus.cpu_addr;
            m_wdata = bus.cpu_wdata;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_done;
        int c_ren;
        int c_ovr;

        n_checks = 0; n_fail = 0;
        done_cnt = 0; ren_ack_cnt = 0; ovr_cnt = 0; ren_acks_at_done = 0; arm_mark = 0;
        rnd_mode = 1'b0; fix_lat = 1;
        d_rnw = 1'b0; d_addr = '0; d_wdata = 8'h00;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rd_req",   32'(bus.ppu_mem_rd_req), 32'd0);
        check_eq("rst_wr_req",   32'(bus.ppu_mem_wr_req), 32'd0);
        check_eq("rst_addr",     32'(bus.ppu_mem_addr),   32'd0);
        check_eq("rst_dout",     32'(bus.ppu_mem_dout),   32'd0);
        check_eq("rst_busy",     32'(bus.cpu_busy),       32'd0);
        check_eq("rst_done",     32'(bus.cpu_done),       32'd0);
        check_eq("rst_overrun",  32'(bus.cpu_overrun),    32'd0);
        check_eq("rst_cpu_rd",   32'(bus.cpu_rdata),      32'd0);
        check_eq("rst_ren_ack",  32'(bus.ren_ack),        32'd0);
        check_eq("rst_ren_rd",   32'(bus.ren_rdata),      32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // CPU write, ack two cycles after the strobe
        fix_lat = 2;
        d_cpu_req = 1'b1; d_rnw = 1'b0; d_addr = 14'h2005; d_wdata = 8'hA5;
        c_done = done_cnt;
        repeat (8) tick();
        check_eq("wr_done_once", 32'(done_cnt - c_done), 32'd1);
        check_eq("wr_busy_low",  32'(bus.cpu_busy),      32'd0);

        // CPU read
        mem[14'h0123] = 8'h3C;
        fix_lat = 1;
        d_cpu_req = 1'b1; d_rnw = 1'b1; d_addr = 14'h0123;
        c_done = done_cnt;
        repeat (8) tick();
        check_eq("rd_done_once", 32'(done_cnt - c_done), 32'd1);
        check_eq("rd_data",      32'(bus.cpu_rdata),     32'h3C);

        // Starvation: CPU read arrives on a render ack with render saturated
        d_ren_on = 1'b1;
        repeat (3) tick();
        d_cpu_arm = 1'b1; d_rnw = 1'b1; d_addr = 14'h2100;
        c_done = done_cnt;
        for (int k = 0; k < 100 && done_cnt == c_done; k++) tick();
        check_eq("starve_done_seen", 32'(done_cnt - c_done), 32'd1);
        check_eq("starve_ren_acks",  32'(ren_acks_at_done - arm_mark), 32'(STARVE_MAX));
        c_ren = ren_ack_cnt;
        repeat (6) tick();
        check_eq("starve_resume", 32'(ren_ack_cnt > c_ren), 32'd1);
        d_ren_on = 1'b0;
        repeat (6) tick();

        // Overrun: second request one cycle after the first
        c_done = done_cnt; c_ovr = ovr_cnt;
        d_cpu_req = 1'b1; d_rnw = 1'b0; d_addr = 14'h2A00; d_wdata = 8'h11;
        tick();
        d_cpu_req = 1'b1; d_rnw = 1'b0; d_addr = 14'h2B00; d_wdata = 8'h22;
        repeat (8) tick();
        check_eq("ovr_once",      32'(ovr_cnt - c_ovr),   32'd1);
        check_eq("ovr_done_once", 32'(done_cnt - c_done), 32'd1);

        // Simultaneous render and CPU requests with an empty slot
        c_done = done_cnt; c_ren = ren_ack_cnt;
        d_ren_on = 1'b1;
        d_cpu_req = 1'b1; d_rnw = 1'b1; d_addr = 14'h2C00;
        tick();
        d_ren_on = 1'b0;
        for (int k = 0; k < 50 && done_cnt == c_done; k++) tick();
        check_eq("sim_done_seen", 32'(done_cnt - c_done), 32'd1);
        check_eq("sim_ren_first", 32'(ren_acks_at_done - c_ren), 32'd1);
        repeat (4) tick();

        // Reset in the middle of a CPU write
        fix_lat = 6;
        d_cpu_req = 1'b1; d_rnw = 1'b0; d_addr = 14'h2D00; d_wdata = 8'h77;
        repeat (4) tick();
        check_eq("mid_wr_active", 32'(bus.ppu_mem_wr_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_wr",   32'(bus.ppu_mem_wr_req), 32'd0);
        check_eq("mid_rst_rd",   32'(bus.ppu_mem_rd_req), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.cpu_busy),       32'd0);
        check_eq("mid_rst_done", 32'(bus.cpu_done),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        d_spur = 1'b1;
        c_done = done_cnt;
        repeat (10) tick();
        check_eq("mid_rst_no_done", 32'(done_cnt - c_done), 32'd0);

        // Randomised traffic
        rnd_mode = 1'b1;
        repeat (3000) tick();
        rnd_mode = 1'b0;
        fix_lat = 1;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppu_vram_arb.md
PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the number of consecutive render grants a pending CPU access tolerates before it is forced next.
REQ-002 Parameter ADDR_W, default 14, SHALL set the PPU address width.
REQ-003 clk  in  1  system clock (25 MHz); one clock; all state SHALL be updated on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ren_req  in  1  render fetch request, level; held until ren_ack.
REQ-006 ren_addr  in  ADDR_W  render fetch address; stable while ren_req is high.
REQ-007 ren_ack  out  1  one-cycle pulse; ren_rdata is valid in the same cycle.
REQ-008 ren_rdata  out  8  render read data.
REQ-009 cpu_req  in  1  one-cycle pulse from the $2007 register path.
REQ-010 cpu_rnw  in  1  1 = read, 0 = write; sampled with cpu_req.
REQ-011 cpu_addr  in  ADDR_W  CPU VRAM address; sampled with cpu_req.
REQ-012 cpu_wdata  in  8  CPU write data; sampled with cpu_req.
REQ-013 cpu_busy  out  1  high while a CPU access is pending or in progress.
REQ-014 cpu_done  out  1  one-cycle pulse at CPU access completion; cpu_rdata is valid for reads.
REQ-015 cpu_rdata  out  8  CPU read data; holds its value until the next CPU read completes.
REQ-016 cpu_overrun  out  1  one-cycle pulse when cpu_req arrives while cpu_busy is high.
REQ-017 ppu_mem_addr  out  ADDR_W  memory address.
REQ-018 ppu_mem_dout  out  8  memory write data.
REQ-019 ppu_mem_rd_req / ppu_mem_wr_req  out  1 each  memory request strobes, level; held until ppu_mem_ack.
REQ-020 ppu_mem_ack  in  1  one-cycle completion pulse from memory; for reads, ppu_mem_din is valid in the same cycle.
REQ-021 ppu_mem_din  in  8  memory read data.

Function
REQ-022 The arbiter SHALL be a state machine with states IDLE, REN_ACC and CPU_ACC.
REQ-023 The CPU request SHALL be latched into a single-entry pending slot (rnw, addr, wdata) when cpu_req=1 and cpu_busy=0; cpu_busy SHALL rise in the next cycle.
REQ-024 cpu_req while cpu_busy=1: the request SHALL be dropped, the slot left unchanged, and cpu_overrun pulsed in the next cycle.
REQ-025 IDLE -> REN_ACC when ren_req=1, unless the CPU slot is pending and starve_cnt == STARVE_MAX.
REQ-026 IDLE -> CPU_ACC when the CPU slot is pending and either ren_req=0 or starve_cnt == STARVE_MAX.
REQ-027 The grant decision SHALL be taken in IDLE; the memory strobe SHALL assert in the first cycle of the access state (one-cycle grant latency).
REQ-028 In REN_ACC: ppu_mem_addr = ren_addr and rd_req=1. On ppu_mem_ack, ren_ack SHALL pulse in the same cycle, ren_rdata SHALL equal ppu_mem_din, and the state SHALL go to IDLE.
REQ-029 In CPU_ACC: ppu_mem_addr = slot address. rd_req is high for reads; wr_req is high with ppu_mem_dout = slot data for writes. On ppu_mem_ack: cpu_done pulses in the next cycle, cpu_rdata is captured (reads only), the slot is cleared, cpu_busy falls together with cpu_done, and the state goes to IDLE.
REQ-030 rd_req and wr_req SHALL never be high together, and both SHALL be low in IDLE.
REQ-031 starve_cnt SHALL be 3 bits wide and SHALL be cleared on every CPU grant and whenever the slot is empty.
REQ-032 starve_cnt SHALL increment on each render grant made while the slot is pending, and SHALL saturate at STARVE_MAX.
REQ-033 Memory outputs SHALL remain stable from strobe assertion until ack; an ack received in IDLE SHALL be ignored.
REQ-034 A cpu_req arriving in the same cycle as the CPU completion SHALL be treated as busy, and therefore dropped with overrun.

Reset
REQ-035 rst_n=0 SHALL immediately force the following values: state IDLE; slot empty; starve_cnt 0; all strobes, acks and pulses 0; ppu_mem_addr 0; ppu_mem_dout 0; ren_rdata 0; cpu_rdata 0.
REQ-036 A reset asserted mid-access SHALL abort the access without any ack or done pulse; requests outstanding at reset SHALL be lost.

Verification
REQ-037 CPU write only: cpu_req with addr 0x2005 and data 0xA5, memory acks 2 cycles after the strobe -> wr_req high with addr 0x2005 and dout 0xA5; cpu_done pulses exactly once; cpu_busy then falls.
REQ-038 CPU read: addr 0x0123, ppu_mem_din = 0x3C at ack -> cpu_rdata = 0x3C and cpu_done pulses exactly once.
REQ-039 Starvation: ren_req held continuously and a CPU read pending, STARVE_MAX=4 -> exactly 4 ren_acks, then 1 CPU access, then render resumes.
REQ-040 Overrun: a second cpu_req 1 cycle after the first -> cpu_overrun pulses once and the first access completes with its original addr/data.
REQ-041 Simultaneous: ren_req and cpu_req in the same cycle with starve_cnt 0 -> the render access is granted first, the CPU access follows, and no strobe overlap occurs.
REQ-042 Reset mid-CPU_ACC: drop rst_n for 1 cycle before the ack -> strobes low immediately, cpu_busy 0, no cpu_done; a later ack is ignored.
